// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave control path: cook-time entry
// FSM encoding, BCD time-buffer geometry and keypad helpers.
package microwave_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int TIME_W     = 16;
  localparam int NUM_KEYS   = 10;
  localparam int COUNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2,
    LOAD         = 2'd3
  } entry_state_t;

  // True when exactly one key is down; zero or several keys never count as a press.
  function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] keys);
    return (keys != '0) && ((keys & (keys - NUM_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/encoder.sv
// One-hot keypad encoder: key i maps to BCD digit i.
module encoder
  import microwave_pkg::*;
(
  input  logic [NUM_KEYS-1:0] onehot,
  output logic [BCD_W-1:0]    digit
);

  // Scan the keys and report the index of the set bit.
  always_comb begin
    // NOTE: default assignment first so every path drives digit and no latch is inferred.
    digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (onehot[i]) digit = BCD_W'(i);
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Cook-time entry: debounces keypad presses, shifts accepted digits into a
// 4-digit MM:SS BCD buffer and offers the finished time to the timer.
module keypad_entry_ctrl
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                clear_key,
  input  logic                start_key,
  input  logic                running,
  input  logic                load_ready,
  output logic                load_valid,
  output logic [TIME_W-1:0]   time_bcd,
  output logic [COUNT_W-1:0]  entry_count
);

  localparam int                  CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [COUNT_W-1:0]  COUNT_MAX = COUNT_W'(NUM_DIGITS);

  entry_state_t          state;
  logic [CNT_W-1:0]      stable_cnt;
  logic [NUM_KEYS-1:0]   pattern;
  logic [NUM_KEYS-1:0]   enc_in;
  logic [BCD_W-1:0]      digit;
  logic                  press_ok;
  logic [CNT_W-1:0]      cnt_inc;
  logic [TIME_W-1:0]     time_shifted;
  logic [COUNT_W-1:0]    count_inc;

  assign press_ok = is_one_hot(keypad);
  assign cnt_inc  = stable_cnt + CNT_W'(1);

  // With a one-cycle debounce the digit is accepted on the same edge the
  // pattern is latched, so the encoder must see the live keypad in IDLE.
  assign enc_in = (DEBOUNCE_CYCLES == 1 && state == IDLE) ? keypad : pattern;

  encoder u_encoder (
    .onehot (enc_in),
    .digit  (digit)
  );

  // Next buffer contents when a digit is accepted; oldest nibble drops off.
  assign time_shifted = {time_bcd[TIME_W-BCD_W-1:0], digit};
  assign count_inc    = (entry_count == COUNT_MAX) ? COUNT_MAX : entry_count + COUNT_W'(1);

  // Entry FSM with registered buffer, digit count and load handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      stable_cnt  <= '0;
      pattern     <= '0;
      time_bcd    <= '0;
      entry_count <= '0;
      load_valid  <= 1'b0;
    end else if (state == LOAD) begin
      // Buffer frozen and keys ignored until the timer takes the time.
      if (load_ready) begin
        load_valid  <= 1'b0;
        time_bcd    <= '0;
        entry_count <= '0;
        state       <= IDLE;
      end
    end else if (running) begin
      // Timer busy: drop any partial press but keep the buffer.
      state      <= IDLE;
      stable_cnt <= '0;
    end else if (clear_key) begin
      // Clear outranks start and any key activity.
      time_bcd    <= '0;
      entry_count <= '0;
      state       <= IDLE;
      stable_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_key && entry_count != '0) begin
            state      <= LOAD;
            load_valid <= 1'b1;
          end else if (press_ok) begin
            pattern <= keypad;
            if (DEBOUNCE_CYCLES == 1) begin
              time_bcd    <= time_shifted;
              entry_count <= count_inc;
              stable_cnt  <= '0;
              state       <= WAIT_RELEASE;
            end else begin
              stable_cnt <= CNT_W'(1);
              state      <= DEBOUNCE;
            end
          end
        end

        DEBOUNCE: begin
          if (keypad == pattern) begin
            if (cnt_inc == CNT_LAST) begin
              time_bcd    <= time_shifted;
              entry_count <= count_inc;
              stable_cnt  <= '0;
              state       <= WAIT_RELEASE;
            end else begin
              stable_cnt <= cnt_inc;
            end
          end else begin
            stable_cnt <= '0;
            state      <= IDLE;
          end
        end

        WAIT_RELEASE: begin
          if (keypad == '0) state <= IDLE;
        end

        default: begin
          state      <= IDLE;
          stable_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: stimulus tasks push expected buffer
// updates and load values; a monitor pops them when the DUT presents them.
module tb_keypad_entry_ctrl;
  import microwave_pkg::*;

  localparam int DC = 4;

  typedef struct {
    logic [15:0] t;
    logic [2:0]  c;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  keypad;
  logic        clear_key;
  logic        start_key;
  logic        running;
  logic        load_ready;
  logic        load_valid;
  logic [15:0] time_bcd;
  logic [2:0]  entry_count;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .keypad      (keypad),
    .clear_key   (clear_key),
    .start_key   (start_key),
    .running     (running),
    .load_ready  (load_ready),
    .load_valid  (load_valid),
    .time_bcd    (time_bcd),
    .entry_count (entry_count)
  );

  always #5 clk = ~clk;

  snap_t       chg_q[$];
  logic [15:0] load_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lv_cycles = 0;
  bit          mon_en = 1'b0;

  // Reference model: the entered time as a plain number and a digit count.
  int m_time  = 0;
  int m_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_set(input int t, input int c);
    snap_t s;
    if (t != m_time || c != m_count) begin
      s.t = 16'(t);
      s.c = 3'(c);
      chg_q.push_back(s);
    end
    m_time  = t;
    m_count = c;
  endtask

  task automatic model_digit(input int d);
    model_set((m_time * 16 + d) % 65536, (m_count < NUM_DIGITS) ? m_count + 1 : NUM_DIGITS);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a pattern for `hold` cycles, then release for two cycles.
  task automatic press(input logic [9:0] p, input int hold);
    int d;
    d = 0;
    for (int i = 0; i < 10; i++) if (p[i]) d = i;
    if ($countones(p) == 1 && hold >= DC && !running) model_digit(d);
    keypad = p;
    repeat (hold) tick();
    keypad = '0;
    repeat (2) tick();
  endtask

  task automatic press_digit(input int d, input int hold);
    logic [9:0] p;
    p = 10'(1) << d;
    press(p, hold);
  endtask

  task automatic do_clear();
    model_set(0, 0);
    clear_key = 1'b1;
    tick();
    clear_key = 1'b0;
    tick();
  endtask

  // Pulse start (optionally with clear); the timer raises ready after `delay` cycles.
  task automatic do_start(input bit clr, input int delay);
    bit expect_load;
    expect_load = !clr && m_count > 0;
    if (clr) model_set(0, 0);
    if (expect_load) load_q.push_back(16'(m_time));
    lv_cycles  = 0;
    load_ready = 1'b0;
    start_key  = 1'b1;
    clear_key  = clr;
    tick();
    start_key = 1'b0;
    clear_key = 1'b0;
    repeat (delay) tick();
    if (expect_load) model_set(0, 0);
    load_ready = 1'b1;
    tick();
    load_ready = 1'b0;
    repeat (2) tick();
    check("load_valid_cycles", lv_cycles, expect_load ? delay + 1 : 0);
  endtask

  task automatic check_state(input string name);
    check({name, "_time"},  time_bcd,    16'(m_time));
    check({name, "_count"}, entry_count, 3'(m_count));
    check({name, "_lv"},    load_valid,  1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an update or a load.
  initial begin
    snap_t prev;
    snap_t exp_s;
    wait (mon_en);
    prev.t = time_bcd;
    prev.c = entry_count;
    forever begin
      @(negedge clk);
      if (load_valid) lv_cycles++;
      if (load_valid && load_ready) begin
        check("load_expected", load_q.size() > 0, 1'b1);
        if (load_q.size() > 0) check("load_time", time_bcd, load_q.pop_front());
      end
      if (time_bcd !== prev.t || entry_count !== prev.c) begin
        check("update_expected", chg_q.size() > 0, 1'b1);
        if (chg_q.size() > 0) begin
          exp_s = chg_q.pop_front();
          check("upd_time",  time_bcd,    exp_s.t);
          check("upd_count", entry_count, exp_s.c);
        end
        prev.t = time_bcd;
        prev.c = entry_count;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 400000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] p;
    int op;
    int a;
    int b;

    reset      = 1'b1;
    keypad     = '0;
    clear_key  = 1'b0;
    start_key  = 1'b0;
    running    = 1'b0;
    load_ready = 1'b0;
    tick();
    tick();
    check("reset_lv",    load_valid,  1'b0);
    check("reset_time",  time_bcd,    16'h0000);
    check("reset_count", entry_count, 3'd0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    // Digit entry: two held keys give exactly two digits.
    press(10'b0000001000, 6);
    press(10'b0000000001, 6);
    check("entry_time",  time_bcd,    16'h0030);
    check("entry_count", entry_count, 3'd2);

    // Bounce and multi-key: no update.
    press(10'b0000100000, 2);
    press(10'b1000000001, 10);
    check_state("bounce");

    // Overflow: five digits keep the last four.
    do_clear();
    for (int d = 1; d <= 5; d++) press_digit(d, DC);
    check("ovf_time",  time_bcd,    16'h2345);
    check("ovf_count", entry_count, 3'd4);

    // Load handshake with ready raised after three cycles.
    do_clear();
    press_digit(9, 5);
    press_digit(0, 5);
    do_start(1'b0, 3);
    check_state("after_load");

    // Clear wins over start; start with nothing entered is ignored.
    press_digit(4, 5);
    press_digit(8, 5);
    do_start(1'b1, 0);
    check_state("clr_start");
    do_start(1'b0, 0);
    check_state("empty_start");

    // Keys ignored while the timer runs.
    press_digit(6, 5);
    running = 1'b1;
    press_digit(2, 8);
    running = 1'b0;
    tick();
    check_state("running");

    // Reset while a load is being offered.
    do_clear();
    press_digit(7, 5);
    press_digit(1, 5);
    load_ready = 1'b0;
    start_key  = 1'b1;
    tick();
    start_key = 1'b0;
    tick();
    check("midload_lv_high", load_valid, 1'b1);
    model_set(0, 0);
    reset = 1'b1;
    tick();
    check("midload_lv",    load_valid,  1'b0);
    check("midload_time",  time_bcd,    16'h0000);
    check("midload_count", entry_count, 3'd0);
    reset = 1'b0;
    tick();
    press_digit(5, 5);
    check_state("post_reset");

    // Randomized mix of presses, glitches, multi-key, clears and loads.
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        press_digit($urandom_range(0, 9), $urandom_range(DC, DC + 3));
      end else if (op == 5) begin
        press_digit($urandom_range(0, 9), $urandom_range(1, DC - 1));
      end else if (op == 6) begin
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        p = 10'($urandom_range(0, 1023));
        p[a] = 1'b1;
        p[b] = 1'b1;
        press(p, $urandom_range(DC, DC + 4));
      end else if (op == 7) begin
        do_clear();
      end else begin
        do_start(op == 9 && $urandom_range(0, 3) == 0, $urandom_range(0, 4));
      end
    end
    check_state("random_end");

    check("update_queue_drained", chg_q.size(),  0);
    check("load_queue_drained",   load_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
